// File: rtl/multi_timer_pkg.sv
// Shared types and helpers for the multi-channel countdown timer.
package multi_timer_pkg;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // Low bit index of channel ch inside a packed CHANNELS*width bus.
  function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One countdown channel: one-shot or auto-reload, stop/abort, sticky pending flag.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             ack_i,
  output logic             done_o,
  output logic             expired_o,
  output logic             pending_o,
  output logic [WIDTH-1:0] value_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  mode_e            mode_q, mode_d;
  logic             pend_q, pend_d;
  logic             exp_q, exp_d;

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    mode_d = mode_q;
    pend_d = pend_q;
    exp_d  = 1'b0;
    if (ack_i) pend_d = 1'b0;
    // A start with count 0 lands the counter at 0, so it never expires.
    if (start_i) begin
      cnt_d  = count_i;
      per_d  = count_i;
      mode_d = mode_e'(mode_i);
    end else if (stop_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '0)) begin
      if (cnt_q == WIDTH'(1)) begin
        exp_d  = 1'b1;
        pend_d = 1'b1;
        cnt_d  = (mode_q == MODE_PERIODIC) ? per_q : '0;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      per_q  <= '0;
      mode_q <= MODE_ONESHOT;
      pend_q <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      exp_q  <= exp_d;
    end
  end

  assign done_o    = (cnt_q == '0);
  assign expired_o = exp_q;
  assign pending_o = pend_q;
  assign value_o   = cnt_q;

endmodule

// File: rtl/multi_timer.sv
// N-channel countdown timer sharing one tick source.
// Optional shared prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4
`ifdef MULTI_TIMER_PRESCALE_EN
 ,parameter int unsigned PRESCALE_W = 8
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
`ifdef MULTI_TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0]     prescale_i,
`endif
  input  logic [CHANNELS-1:0]       start_i,
  input  logic [CHANNELS-1:0]       stop_i,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS*WIDTH-1:0] count_i,
  input  logic [CHANNELS-1:0]       ack_i,
  output logic [CHANNELS-1:0]       done_o,
  output logic [CHANNELS-1:0]       expired_o,
  output logic [CHANNELS-1:0]       pending_o,
  output logic [CHANNELS*WIDTH-1:0] value_o,
  output logic                      irq_o
);

  logic tick;

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] div_q, div_d;

  // prescale_i is only reloaded on wrap, so changes apply at the next period boundary.
  always_comb begin
    div_d = div_q - PRESCALE_W'(1);
    if (div_q == '0) div_d = prescale_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) div_q <= '0;
    else         div_q <= div_d;
  end

  assign tick = (div_q == '0);
`else
  assign tick = 1'b1;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    multi_timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .tick_i   (tick),
      .start_i  (start_i[c]),
      .stop_i   (stop_i[c]),
      .mode_i   (mode_i[c]),
      .count_i  (count_i[ch_lo(c, WIDTH) +: WIDTH]),
      .ack_i    (ack_i[c]),
      .done_o   (done_o[c]),
      .expired_o(expired_o[c]),
      .pending_o(pending_o[c]),
      .value_o  (value_o[ch_lo(c, WIDTH) +: WIDTH])
    );
  end

  assign irq_o = |pending_o;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer (CHANNELS=4, WIDTH=8).
module tb_multi_timer;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [C-1:0]   start_i, stop_i, mode_i, ack_i;
  logic [C*W-1:0] count_i;
  logic [C-1:0]   done_o, expired_o, pending_o;
  logic [C*W-1:0] value_o;
  logic           irq_o;
`ifdef MULTI_TIMER_PRESCALE_EN
  logic [7:0]     prescale_i;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  multi_timer #(
    .WIDTH   (W),
    .CHANNELS(C)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
`ifdef MULTI_TIMER_PRESCALE_EN
    .prescale_i(prescale_i),
`endif
    .start_i  (start_i),
    .stop_i   (stop_i),
    .mode_i   (mode_i),
    .count_i  (count_i),
    .ack_i    (ack_i),
    .done_o   (done_o),
    .expired_o(expired_o),
    .pending_o(pending_o),
    .value_o  (value_o),
    .irq_o    (irq_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] val(input int unsigned c);
    return value_o[c*W +: W];
  endfunction

  task automatic load(input int unsigned c, input logic [W-1:0] n, input logic m);
    start_i[c]       = 1'b1;
    mode_i[c]        = m;
    count_i[c*W +: W] = n;
  endtask

  initial begin
    int unsigned first_exp;
    int unsigned exp_cnt;
    rst_ni  = 1'b0;
    start_i = '0;
    stop_i  = '0;
    mode_i  = '0;
    ack_i   = '0;
    count_i = '0;
`ifdef MULTI_TIMER_PRESCALE_EN
    prescale_i = '0;
`endif
    step();
    step();
    check("rst_done",    32'(done_o),    32'hF);
    check("rst_pending", 32'(pending_o), 32'h0);
    check("rst_expired", 32'(expired_o), 32'h0);
    check("rst_irq",     32'(irq_o),     32'h0);
    check("rst_value",   value_o,        32'h0);
    rst_ni = 1'b1;

    // ch0 one-shot, count 5
    load(0, 8'd5, 1'b0);
    step();
    start_i = '0;
    check("os_load", 32'(val(0)), 32'd5);
    check("os_busy", 32'(done_o[0]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("os_val", 32'(val(0)), 32'(5 - k));
      check("os_noexp", 32'(expired_o[0]), 32'd0);
    end
    step();
    check("os_end_val", 32'(val(0)), 32'd0);
    check("os_done", 32'(done_o[0]), 32'd1);
    check("os_exp", 32'(expired_o[0]), 32'd1);
    check("os_pend", 32'(pending_o[0]), 32'd1);
    check("os_irq", 32'(irq_o), 32'd1);
    step();
    check("os_exp_pulse", 32'(expired_o[0]), 32'd0);
    check("os_pend_sticky", 32'(pending_o[0]), 32'd1);
    ack_i[0] = 1'b1;
    step();
    ack_i = '0;
    check("os_ack", 32'(pending_o[0]), 32'd0);
    check("os_irq_clr", 32'(irq_o), 32'd0);

    // ch1 periodic, count 3, stopped after the second expiry
    load(1, 8'd3, 1'b1);
    step();
    start_i = '0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 7) stop_i[1] = 1'b1;
      step();
      stop_i = '0;
      check("per_exp", 32'(expired_o[1]), 32'((k == 3) || (k == 6)));
      check("per_done", 32'(done_o[1]), 32'(k >= 7));
      if (k == 7) check("per_stop_val", 32'(val(1)), 32'd0);
    end
    check("per_pend_kept", 32'(pending_o[1]), 32'd1);
    ack_i[1] = 1'b1;
    step();
    ack_i = '0;
    check("per_ack", 32'(pending_o[1]), 32'd0);

    // ch0 periodic, count 1: expires every cycle
    load(0, 8'd1, 1'b1);
    step();
    start_i = '0;
    check("p1_val", 32'(val(0)), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("p1_exp", 32'(expired_o[0]), 32'd1);
      check("p1_done", 32'(done_o[0]), 32'd0);
    end
    stop_i[0] = 1'b1;
    step();
    stop_i = '0;
    check("p1_stop_exp", 32'(expired_o[0]), 32'd0);
    check("p1_stop_done", 32'(done_o[0]), 32'd1);
    ack_i[0] = 1'b1;
    step();
    ack_i = '0;

    // ch2 start with 0, then restart mid-count
    load(2, 8'd0, 1'b0);
    step();
    start_i = '0;
    check("z_done", 32'(done_o[2]), 32'd1);
    step();
    check("z_exp", 32'(expired_o[2]), 32'd0);
    check("z_pend", 32'(pending_o[2]), 32'd0);
    load(2, 8'd6, 1'b0);
    step();
    start_i = '0;
    step();
    check("rs_val1", 32'(val(2)), 32'd5);
    load(2, 8'd4, 1'b0);
    step();
    start_i = '0;
    check("rs_val2", 32'(val(2)), 32'd4);
    exp_cnt = 0;
    for (int k = 3; k <= 10; k++) begin
      step();
      if (expired_o[2]) exp_cnt++;
      check("rs_exp", 32'(expired_o[2]), 32'(k == 6));
    end
    check("rs_exp_count", exp_cnt, 32'd1);
    ack_i[2] = 1'b1;
    step();
    ack_i = '0;

    // ch3: ack coincides with expiry, set wins
    load(3, 8'd3, 1'b0);
    step();
    start_i = '0;
    step();
    step();
    ack_i[3] = 1'b1;
    step();
    ack_i = '0;
    check("coin_exp", 32'(expired_o[3]), 32'd1);
    check("coin_pend", 32'(pending_o[3]), 32'd1);
    step();
    check("coin_pend_hold", 32'(pending_o[3]), 32'd1);
    ack_i[3] = 1'b1;
    step();
    ack_i = '0;
    check("coin_ack", 32'(pending_o[3]), 32'd0);

    // reset mid-count on every channel
    for (int c = 0; c < 4; c++) load(c, 8'd3, c[0]);
    step();
    start_i = '0;
    step();
    rst_ni = 1'b0;
    step();
    check("mrst_value", value_o, 32'h0);
    check("mrst_done", 32'(done_o), 32'hF);
    check("mrst_exp", 32'(expired_o), 32'h0);
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mrst_noexp", 32'(expired_o), 32'h0);
    end
    check("mrst_irq", 32'(irq_o), 32'd0);

`ifdef MULTI_TIMER_PRESCALE_EN
    prescale_i = 8'd3;
    repeat (5) step();
    load(0, 8'd2, 1'b0);
    step();
    start_i = '0;
    first_exp = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (expired_o[0] && first_exp == 0) first_exp = k;
    end
    check("ps3_lat_ok", 32'((first_exp >= 5) && (first_exp <= 8)), 32'd1);
    prescale_i = 8'd0;
    repeat (6) step();
    load(0, 8'd2, 1'b0);
    step();
    start_i = '0;
    first_exp = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (expired_o[0] && first_exp == 0) first_exp = k;
    end
    check("ps0_lat", first_exp, 32'd2);
`else
    first_exp = 0;
    check("no_ps_placeholder_irq", 32'(irq_o), 32'(first_exp));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
